// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential imem reads and buffers {instr, pc} for decode.
// Latency: request in cycle N, queue push at N+1, presented to decode (id_valid) at N+2.
// Backpressure: requests are credit-limited (queued + in flight < DEPTH); id_ready=0 holds the head.
//
// Ports:
//   clk, rst              single clock; asynchronous active-low reset
//   imem_req/imem_addr    read request to instruction memory (one per cycle max)
//   imem_rdata            read data, valid the cycle after the request
//   redirect_valid/_pc    flush queue, squash in-flight response, restart fetch at redirect_pc
//   id_valid/instr/pc     queue head presented to decode; id_ready accepts it
//   stall_cnt, flush_cnt  optional saturating counters, present only with IFQ_PERF_CNT_EN defined
module instr_fetch_queue #(
   parameter int               ADDR_W   = 8,
   parameter int               INSTR_W  = 9,
   parameter int               DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   input  logic               id_ready
`ifdef IFQ_PERF_CNT_EN
   ,
   output logic [15:0]        stall_cnt,
   output logic [7:0]         flush_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [INSTR_W-1:0] q_instr [DEPTH];
   logic [ADDR_W-1:0]  q_pc    [DEPTH];

   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  inflight_pc;
   logic               inflight;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic [CW:0]        occupancy;
   logic               head_vld;
   logic               push;
   logic               pop;

   // The in-flight response already owns a slot, so it counts against the credit.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign imem_req  = rst & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
   assign imem_addr = pc;

   assign head_vld  = (count != '0);
   assign id_valid  = head_vld & ~redirect_valid;
   // Head data is forced to zero when the queue is empty so reset leaves clean outputs.
   assign id_instr  = head_vld ? q_instr[rd_ptr] : '0;
   assign id_pc     = head_vld ? q_pc[rd_ptr]    : '0;

   // A response landing in a redirect cycle belongs to the old path and is dropped.
   assign push = inflight & ~redirect_valid;
   assign pop  = id_valid & id_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_PC;
         inflight_pc <= '0;
         inflight    <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else if (redirect_valid) begin
         pc       <= redirect_pc;
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            pc          <= pc + ADDR_W'(1);
            inflight_pc <= pc;
         end
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (!push && pop)
            count <= count - CW'(1);
      end
   end

   // Storage needs no reset: entries are only visible through head_vld.
   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr]    <= inflight_pc;
      end
   end

`ifdef IFQ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (id_ready && !id_valid && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (redirect_valid && (flush_cnt != 8'hFF))
            flush_cnt <= flush_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a RESET_PC=0 instance carries most scenarios,
// a RESET_PC=0xFE instance checks pc wrap-around. Inputs change on the falling edge,
// outputs are sampled 1ns later.
module tb_instr_fetch_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic [8:0] imem_rdata;
   logic       redirect_valid;
   logic [7:0] redirect_pc;
   logic       id_valid;
   logic [8:0] id_instr;
   logic [7:0] id_pc;
   logic       id_ready;

   logic       imem_req_w;
   logic [7:0] imem_addr_w;
   logic [8:0] imem_rdata_w;
   logic       redirect_valid_w = 1'b0;
   logic [7:0] redirect_pc_w    = 8'h00;
   logic       id_valid_w;
   logic [8:0] id_instr_w;
   logic [7:0] id_pc_w;
   logic       id_ready_w       = 1'b1;

`ifdef IFQ_PERF_CNT_EN
   logic [15:0] stall_cnt, stall_cnt_w;
   logic [7:0]  flush_cnt, flush_cnt_w;
`endif

   logic [8:0] mem [256];
   int         n_cmp = 0;
   int         n_err = 0;
   int         req_cnt = 0;

   always #5 clk = ~clk;

   instr_fetch_queue #(.ADDR_W(8), .INSTR_W(9), .DEPTH(4), .RESET_PC(8'h00)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_ready       (id_ready)
`ifdef IFQ_PERF_CNT_EN
      ,
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
`endif
   );

   instr_fetch_queue #(.ADDR_W(8), .INSTR_W(9), .DEPTH(4), .RESET_PC(8'hFE)) u_dut_wrap (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req_w),
      .imem_addr      (imem_addr_w),
      .imem_rdata     (imem_rdata_w),
      .redirect_valid (redirect_valid_w),
      .redirect_pc    (redirect_pc_w),
      .id_valid       (id_valid_w),
      .id_instr       (id_instr_w),
      .id_pc          (id_pc_w),
      .id_ready       (id_ready_w)
`ifdef IFQ_PERF_CNT_EN
      ,
      .stall_cnt      (stall_cnt_w),
      .flush_cnt      (flush_cnt_w)
`endif
   );

   // Synchronous instruction memories: data returns the cycle after the request.
   always @(posedge clk) begin
      if (imem_req)   imem_rdata   <= mem[imem_addr];
      if (imem_req_w) imem_rdata_w <= mem[imem_addr_w];
      if (imem_req)   req_cnt      <= req_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_pc_a [3];
      logic [8:0] exp_in_a [3];
      logic [7:0] exp_wpc  [4];
      int         req_base;

      exp_pc_a = '{8'h00, 8'h01, 8'h02};
      exp_in_a = '{9'h00A, 9'h09C, 9'h04B};
      exp_wpc  = '{8'hFE, 8'hFF, 8'h00, 8'h01};

      for (int i = 0; i < 256; i++) mem[i] = 9'((i * 37 + 5) & 9'h1FF);
      mem[0] = 9'h00A;
      mem[1] = 9'h09C;
      mem[2] = 9'h04B;

      rst            = 1'b0;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;

      // Reset state
      #1;
      chk("rst_req",   32'(imem_req), 32'd0);
      chk("rst_vld",   32'(id_valid), 32'd0);
      chk("rst_instr", 32'(id_instr), 32'd0);
      chk("rst_pc",    32'(id_pc),    32'd0);

      // Reset release, streaming with id_ready=1
      @(negedge clk); rst = 1'b1; #1;
      chk("a_req0",  32'(imem_req),  32'd1);
      chk("a_addr0", 32'(imem_addr), 32'd0);
      chk("a_vld0",  32'(id_valid),  32'd0);
      @(negedge clk); #1;
      chk("a_vld1",  32'(id_valid),  32'd0);
      chk("a_addr1", 32'(imem_addr), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("a_vld",   32'(id_valid), 32'd1);
         chk("a_pc",    32'(id_pc),    32'(exp_pc_a[i]));
         chk("a_instr", 32'(id_instr), 32'(exp_in_a[i]));
      end

      // Stall one cycle to reach 2 queued + 1 in flight, then reset mid-operation
      id_ready = 1'b0;
      @(negedge clk); rst = 1'b0; #1;
      chk("mr_req",   32'(imem_req), 32'd0);
      chk("mr_vld",   32'(id_valid), 32'd0);
      chk("mr_instr", 32'(id_instr), 32'd0);
      chk("mr_pc",    32'(id_pc),    32'd0);
      @(negedge clk);
      @(negedge clk);

      // Release with id_ready=0: credits allow exactly DEPTH requests
      @(negedge clk); rst = 1'b1; req_base = req_cnt; #1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk); #1;
         if (i >= 2 && i <= 5) begin
            chk("w_vld", 32'(id_valid_w), 32'd1);
            chk("w_pc",  32'(id_pc_w),    32'(exp_wpc[i-2]));
            chk("w_instr", 32'(id_instr_w), 32'(mem[exp_wpc[i-2]]));
         end
      end
      chk("b_reqs",  32'(req_cnt - req_base), 32'd4);
      chk("b_req",   32'(imem_req), 32'd0);
      chk("b_vld",   32'(id_valid), 32'd1);
      chk("b_pc",    32'(id_pc),    32'd0);
      chk("b_instr", 32'(id_instr), 32'h00A);
      id_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk); #1;
         chk("b_drain_vld",   32'(id_valid), 32'd1);
         chk("b_drain_pc",    32'(id_pc),    32'(k));
         chk("b_drain_instr", 32'(id_instr), 32'(mem[k]));
      end

      // One stalled cycle leaves 3 queued + 1 in flight, then redirect
      id_ready = 1'b0;
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 8'h40; id_ready = 1'b1; #1;
      chk("r_vld0", 32'(id_valid), 32'd0);
      chk("r_req0", 32'(imem_req), 32'd0);
      @(negedge clk); redirect_valid = 1'b0; #1;
      chk("r_vld1",  32'(id_valid),  32'd0);
      chk("r_req1",  32'(imem_req),  32'd1);
      chk("r_addr1", 32'(imem_addr), 32'h40);
      @(negedge clk); #1;
      chk("r_vld2", 32'(id_valid), 32'd0);
      @(negedge clk); #1;
      chk("r_vld3",   32'(id_valid), 32'd1);
      chk("r_pc3",    32'(id_pc),    32'h40);
      chk("r_instr3", 32'(id_instr), 32'(mem[8'h40]));
      @(negedge clk); #1;
      chk("r_pc4", 32'(id_pc), 32'h41);

      // Head holds while decode is not ready
      id_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         chk("h_vld",   32'(id_valid), 32'd1);
         chk("h_pc",    32'(id_pc),    32'h41);
         chk("h_instr", 32'(id_instr), 32'(mem[8'h41]));
      end

`ifdef IFQ_PERF_CNT_EN
      @(negedge clk); rst = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; #1;
      chk("p_stall_rst", 32'(stall_cnt), 32'd0);
      chk("p_flush_rst", 32'(flush_cnt), 32'd0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 8'h10; id_ready = 1'b1;
      @(negedge clk); redirect_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); redirect_valid = 1'b1;
      @(negedge clk); redirect_valid = 1'b0;
      @(negedge clk); id_ready = 1'b0;
      @(negedge clk); #1;
      chk("p_stall", 32'(stall_cnt), 32'd5);
      chk("p_flush", 32'(flush_cnt), 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction address width.
REQ-002 SHALL have parameter INSTR_W, default 9, instruction width (opcode[8:6], rd[5:3], rs[2:0]).
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port imem_req, output, 1, instruction memory read request.
REQ-008 SHALL have port imem_addr, output, ADDR_W, read address, valid while imem_req is high.
REQ-009 SHALL have port imem_rdata, input, INSTR_W, read data, valid exactly one cycle after the request.
REQ-010 SHALL have port redirect_valid, input, 1, branch/jump redirect strobe.
REQ-011 SHALL have port redirect_pc, input, ADDR_W, new fetch address.
REQ-012 SHALL have port id_valid, output, 1, queue head is presented to decode.
REQ-013 SHALL have port id_instr, output, INSTR_W, head instruction.
REQ-014 SHALL have port id_pc, output, ADDR_W, head instruction address.
REQ-015 SHALL have port id_ready, input, 1, decode accepts the head.

Function
REQ-016 SHALL issue imem_req with imem_addr=pc whenever count + inflight < DEPTH and redirect_valid=0; pc increments by 1 per request, wrapping from 2^ADDR_W-1 to 0.
REQ-017 SHALL set inflight=1 for the cycle after each request and push {imem_rdata, issued address} into the queue in that cycle unless the response is squashed.
REQ-018 SHALL drive id_valid = (count != 0) & ~redirect_valid; a pop occurs only when id_valid & id_ready.
REQ-019 SHALL, in the same cycle, push and pop without loss; count is unchanged and the pointers each advance modulo DEPTH.
REQ-020 SHALL never push when full: the credit rule in REQ-016 guarantees this, and no bypass from imem_rdata to id_instr exists.
REQ-021 SHALL, on redirect_valid, clear count and pointers, squash any in-flight response arriving next cycle, load pc=redirect_pc, and suppress imem_req that cycle; the first fetch at redirect_pc is issued the following cycle.
REQ-022 SHALL give redirect priority over a simultaneous push, pop or request.
REQ-023 SHALL hold id_instr and id_pc stable while id_valid=1 and id_ready=0.
REQ-024 SHALL have a latency of 2 cycles from request to id_valid: request in cycle N, push at N+1, id_valid at N+2.
REQ-025 SHALL sustain one instruction per cycle once primed with id_ready held high.

Reset
REQ-026 SHALL, while rst=0, force pc=RESET_PC, count=0, pointers=0, inflight=0, imem_req=0, id_valid=0, id_instr=0 and id_pc=0.
REQ-027 SHALL discard any in-flight response when reset is asserted mid-operation; the first request is issued in the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with IFQ_PERF_CNT_EN defined, add outputs stall_cnt[15:0], counting cycles with id_ready=1 and id_valid=0, and flush_cnt[7:0], counting redirects; both are saturating, and both reset to 0.
REQ-029 SHALL, without IFQ_PERF_CNT_EN, omit those ports and counters entirely, with no other behavioural change.

Verification
REQ-030 Reset release with memory[0..2] = 0x00A, 0x09C, 0x04B and id_ready=1 -> id_valid first high 2 cycles after the first request; id_pc/id_instr = 0/0x00A, 1/0x09C, 2/0x04B on consecutive cycles.
REQ-031 id_ready=0 for 10 cycles -> exactly 4 requests issued, imem_req low with count=4, head stays pc 0; on id_ready=1, 4 consecutive pops followed by continued refill.
REQ-032 redirect_valid with redirect_pc=0x40 while the queue holds 3 entries and one is in flight -> id_valid low that cycle, the squashed response is never presented, and the next id_pc is 0x40.
REQ-033 Start at RESET_PC=0xFE -> id_pc sequence is 0xFE, 0xFF, 0x00, 0x01.
REQ-034 rst asserted while 2 entries are queued and one is in flight -> all outputs are 0 immediately; after release, fetch restarts at RESET_PC with no stale entries.
REQ-035 With IFQ_PERF_CNT_EN, 5 starved ready cycles plus 2 redirects -> stall_cnt=5 and flush_cnt=2.
